// File: rtl/svf_sc_ctrl.sv
// svf_sc_ctrl: drives sc_clk, the C_Q bits and the response select of the SC SVF macro.
// Settings are written byte-wide, staged, then applied only on the sc_clk falling edge that ends a period.
// The optional glide moves the divider one step per period toward the target.
module svf_sc_ctrl #(
  parameter int DIV_W      = 11,
  parameter int GLIDE_STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       sc_clk,
  output logic       q0,
  output logic       q1,
  output logic       q2,
  output logic       q3,
  output logic       sel0,
  output logic       sel1,
  output logic       busy
);

  localparam logic [DIV_W-1:0] STEP = DIV_W'(GLIDE_STEP);
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

  // Divider state.
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic             sc_r, sc_nxt;
  logic             boundary;

  // Settings, staged copies and pending flags.
  logic [DIV_W-1:0] d_act, d_tgt, d_nxt, d_glide, gap, stp;
  logic             glide_up;
  logic [7:0]       lo_stage;
  logic [3:0]       q_stg, q_out, q_nxt;
  logic [1:0]       sel_stg, sel_out, sel_nxt;
  logic             en, glide;
  logic             pend_div, pend_div_nxt;
  logic             pend_qm, pend_qm_nxt;
  logic             busy_r;

  logic             wr_lo, wr_div, wr_qm, wr_ctl;

  assign wr_lo  = wr_en && (wr_addr == 2'd0);
  assign wr_div = wr_en && (wr_addr == 2'd1);
  assign wr_qm  = wr_en && (wr_addr == 2'd2);
  assign wr_ctl = wr_en && (wr_addr == 2'd3);

  // Divider: toggle at counter==D; a period ends on the falling toggle, and every cycle is a boundary while disabled.
  always_comb begin
    cnt_nxt  = cnt;
    sc_nxt   = sc_r;
    boundary = 1'b1;
    if (!en) begin
      cnt_nxt = '0;
      sc_nxt  = 1'b0;
    end else if (cnt == d_act) begin
      cnt_nxt  = '0;
      sc_nxt   = ~sc_r;
      boundary = sc_r;
    end else begin
      cnt_nxt  = cnt + ONE;
      boundary = 1'b0;
    end
  end

  // Glide candidate: move D toward the target by at most STEP, never overshooting.
  always_comb begin
    glide_up = (d_tgt > d_act);
    gap      = glide_up ? (d_tgt - d_act) : (d_act - d_tgt);
    stp      = (gap > STEP) ? STEP : gap;
    d_glide  = glide_up ? (d_act + stp) : (d_act - stp);
  end

  // Apply pending settings on a boundary; a write in the same cycle re-arms its pending flag for the next boundary.
  always_comb begin
    d_nxt        = d_act;
    pend_div_nxt = pend_div;
    q_nxt        = q_out;
    sel_nxt      = sel_out;
    pend_qm_nxt  = pend_qm;
    if (boundary && pend_div) begin
      d_nxt = (en && glide) ? d_glide : d_tgt;
      if (((en && glide) ? d_glide : d_tgt) == d_tgt) begin
        pend_div_nxt = 1'b0;
      end
    end
    if (boundary && pend_qm) begin
      q_nxt       = q_stg;
      sel_nxt     = sel_stg;
      pend_qm_nxt = 1'b0;
    end
    if (wr_div) begin
      pend_div_nxt = 1'b1;
    end
    if (wr_qm) begin
      pend_qm_nxt = 1'b1;
    end
  end

  // State and output registers; the register-port writes land here too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sc_r     <= 1'b0;
      d_act    <= '0;
      d_tgt    <= '0;
      lo_stage <= '0;
      q_stg    <= '0;
      sel_stg  <= '0;
      q_out    <= '0;
      sel_out  <= '0;
      en       <= 1'b0;
      glide    <= 1'b0;
      pend_div <= 1'b0;
      pend_qm  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      sc_r     <= sc_nxt;
      d_act    <= d_nxt;
      q_out    <= q_nxt;
      sel_out  <= sel_nxt;
      pend_div <= pend_div_nxt;
      pend_qm  <= pend_qm_nxt;
      busy_r   <= pend_div_nxt | pend_qm_nxt;
      if (wr_lo) begin
        lo_stage <= wr_data;
      end
      if (wr_div) begin
        d_tgt <= {wr_data[DIV_W-9:0], lo_stage};
      end
      if (wr_qm) begin
        q_stg   <= wr_data[3:0];
        sel_stg <= wr_data[5:4];
      end
      if (wr_ctl) begin
        en    <= wr_data[0];
        glide <= wr_data[1];
      end
    end
  end

  assign sc_clk = sc_r;
  assign q0     = q_out[0];
  assign q1     = q_out[1];
  assign q2     = q_out[2];
  assign q3     = q_out[3];
  assign sel0   = sel_out[0];
  assign sel1   = sel_out[1];
  assign busy   = busy_r;

endmodule

// File: tb/tb_svf_sc_ctrl.sv
// Bench for svf_sc_ctrl: directed scenarios plus random register traffic,
// every cycle compared against a period-position reference model.
module tb_svf_sc_ctrl;
  localparam int DIV_W      = 11;
  localparam int GLIDE_STEP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       sc_clk, q0, q1, q2, q3, sel0, sel1, busy;

  svf_sc_ctrl #(.DIV_W(DIV_W), .GLIDE_STEP(GLIDE_STEP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sc_clk(sc_clk), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .sel0(sel0), .sel1(sel1), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int per[8];

  // Reference model: position within the sc_clk period (0 .. 2D+1), high half is pos >= D+1.
  int         m_pos, m_d, m_tgt;
  logic [7:0] m_lo;
  logic [3:0] m_sq, m_q;
  logic [1:0] m_ssel, m_sel;
  bit         m_en, m_glide, m_pd, m_pq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_pos = 0; m_d = 0; m_tgt = 0; m_lo = 0;
    m_sq = 0; m_q = 0; m_ssel = 0; m_sel = 0;
    m_en = 0; m_glide = 0; m_pd = 0; m_pq = 0;
  endfunction

  function automatic void model_edge();
    bit bnd;
    int gap;
    bnd = m_en ? (m_pos == 2 * m_d + 1) : 1'b1;
    if (!m_en || m_pos == 2 * m_d + 1) m_pos = 0;
    else m_pos = m_pos + 1;
    if (bnd && m_pq) begin
      m_q = m_sq; m_sel = m_ssel; m_pq = 0;
    end
    if (bnd && m_pd) begin
      if (!m_en || !m_glide) m_d = m_tgt;
      else begin
        gap = (m_tgt > m_d) ? m_tgt - m_d : m_d - m_tgt;
        if (gap > GLIDE_STEP) gap = GLIDE_STEP;
        m_d = (m_tgt > m_d) ? m_d + gap : m_d - gap;
      end
      if (m_d == m_tgt) m_pd = 0;
    end
    if (wr_en) begin
      case (wr_addr)
        2'd0: m_lo = wr_data;
        2'd1: begin
          m_tgt = int'(wr_data[DIV_W-9:0]) * 256 + int'(m_lo);
          m_pd  = 1;
        end
        2'd2: begin
          m_sq = wr_data[3:0]; m_ssel = wr_data[5:4]; m_pq = 1;
        end
        default: begin
          m_en = wr_data[0]; m_glide = wr_data[1];
        end
      endcase
    end
  endfunction

  function automatic logic [7:0] obs();
    return {sc_clk, q3, q2, q1, q0, sel1, sel0, busy};
  endfunction

  function automatic logic [7:0] expv();
    logic sc;
    sc = (m_pos >= m_d + 1);
    return {sc, m_q, m_sel, (m_pd | m_pq)};
  endfunction

  // One clock: drive inputs, model the edge, check all outputs at the following negedge.
  task automatic step(input bit we, input logic [1:0] a, input logic [7:0] d);
    wr_en = we; wr_addr = a; wr_data = d;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    wr_en = 1'b0;
    chk("outs", {24'd0, obs()}, {24'd0, expv()});
  endtask

  // Record n full periods, measured falling edge to falling edge.
  task automatic measure(input int n, input int limit);
    int last = -1;
    int k = 0;
    int t = 0;
    logic prev;
    prev = sc_clk;
    while (k < n && t < limit) begin
      step(1'b0, 2'd0, 8'd0);
      t++;
      if (prev && !sc_clk) begin
        if (last >= 0) begin
          per[k] = cyc - last;
          k++;
        end
        last = cyc;
      end
      prev = sc_clk;
    end
    if (k < n) chk("measure_timeout", k, n);
  endtask

  task automatic to_fall(input int limit);
    int t = 0;
    bit got = 0;
    logic prev;
    prev = sc_clk;
    while (!got && t < limit) begin
      step(1'b0, 2'd0, 8'd0);
      t++;
      if (prev && !sc_clk) got = 1;
      prev = sc_clk;
    end
    if (!got) chk("fall_timeout", t, 0);
  endtask

  logic [5:0] pre_qs;
  logic [1:0] ra;
  logic [7:0] rd;

  initial begin
    model_reset();
    @(negedge clk);
    chk("reset", {24'd0, obs()}, 32'd0);
    rst = 1'b0;

    // D=0: period 2, nothing pending.
    step(1'b1, 2'd3, 8'h01);
    measure(3, 40);
    for (int k = 0; k < 3; k++) chk("per_d0", per[k], 2);
    chk("idle_qsel_busy", {q3, q2, q1, q0, sel1, sel0, busy}, 0);

    // D=3, then retarget to D=300.
    step(1'b1, 2'd0, 8'd3);
    step(1'b1, 2'd1, 8'd0);
    measure(2, 100);
    chk("per_d3_a", per[1], 8);
    step(1'b0, 2'd0, 8'd0);
    step(1'b1, 2'd0, 8'h2C);
    step(1'b1, 2'd1, 8'h01);
    chk("busy_div_set", busy, 1);
    measure(1, 1500);
    chk("per_d300", per[0], 602);
    chk("busy_div_clr", busy, 0);

    // Back to D=3.
    step(1'b1, 2'd0, 8'd3);
    step(1'b1, 2'd1, 8'd0);
    measure(2, 1400);
    chk("per_d3_b", per[1], 8);

    // q/sel write mid-period changes only on the falling edge.
    for (int t = 0; t < 20 && !sc_clk; t++) step(1'b0, 2'd0, 8'd0);
    chk("wait_high", sc_clk, 1);
    step(1'b1, 2'd2, 8'h2B);
    pre_qs = {q3, q2, q1, q0, sel1, sel0};
    for (int t = 0; t < 20 && sc_clk; t++) begin
      pre_qs = {q3, q2, q1, q0, sel1, sel0};
      step(1'b0, 2'd0, 8'd0);
    end
    chk("qsel_before_fall", pre_qs, 6'b0000_00);
    chk("qsel_after_fall", {q3, q2, q1, q0, sel1, sel0}, 6'b1011_10);

    // Glide from D=10 to D=14.
    step(1'b1, 2'd0, 8'd10);
    step(1'b1, 2'd1, 8'd0);
    measure(2, 100);
    step(1'b1, 2'd3, 8'h03);
    step(1'b1, 2'd0, 8'd14);
    step(1'b1, 2'd1, 8'd0);
    measure(5, 400);
    chk("glide_p11", per[0], 24);
    chk("glide_p12", per[1], 26);
    chk("glide_p13", per[2], 28);
    chk("glide_p14", per[3], 30);
    chk("glide_busy_clr", busy, 0);

    // Write in the exact boundary cycle: old staged value now, new one a period later.
    step(1'b1, 2'd3, 8'h01);
    step(1'b1, 2'd0, 8'd2);
    step(1'b1, 2'd1, 8'd0);
    to_fall(100);
    step(1'b1, 2'd2, 8'h15);
    for (int t = 0; t < 40 && !(m_en && m_pos == 2 * m_d + 1); t++) step(1'b0, 2'd0, 8'd0);
    step(1'b1, 2'd2, 8'h3A);
    chk("coinc_old", {q3, q2, q1, q0, sel1, sel0}, 6'b0101_01);
    chk("coinc_busy", busy, 1);
    to_fall(40);
    chk("coinc_new", {q3, q2, q1, q0, sel1, sel0}, 6'b1010_11);
    chk("coinc_busy_clr", busy, 0);

    // Async reset mid-period with sc_clk high and a setting pending.
    step(1'b1, 2'd0, 8'd5);
    step(1'b1, 2'd1, 8'd0);
    to_fall(40);
    for (int t = 0; t < 20 && !sc_clk; t++) step(1'b0, 2'd0, 8'd0);
    step(1'b1, 2'd2, 8'h0F);
    chk("pre_rst_state", {sc_clk, busy}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("rst_async", {24'd0, obs()}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 5; t++) step(1'b0, 2'd0, 8'd0);
    chk("post_rst_idle", {sc_clk, busy}, 2'b00);

    // Random register traffic.
    step(1'b1, 2'd3, 8'h01);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ra = 2'($urandom_range(0, 3));
        case (ra)
          2'd0: rd = 8'($urandom_range(0, 12));
          2'd1: rd = 8'($urandom_range(0, 1) * 8);
          2'd2: rd = 8'($urandom);
          default: rd = 8'(($urandom & 32'hFC) | ($urandom_range(0, 1) * 2)
                        | (($urandom_range(0, 3) != 0) ? 1 : 0));
        endcase
        step(1'b1, ra, rd);
      end else begin
        step(1'b0, 2'd0, 8'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
